// File: rtl/pe_link_pkg.sv
// Shared link-word definitions for the PE stream-to-link packer: field positions,
// default geometry and a link-word pack helper.
package pe_link_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LANES      = 4;
    localparam int DEF_LINK_WIDTH = DEF_LANES * DEF_DATA_W + 2;

    localparam int LINK_VALID_BIT = DEF_LINK_WIDTH - 1;
    localparam int LINK_LAST_BIT  = DEF_LINK_WIDTH - 2;

    function automatic int lane_offset(input int lane, input int data_w);
        return lane * data_w;
    endfunction

    function automatic logic [DEF_LINK_WIDTH-1:0] pack_link(
        input logic                              valid,
        input logic                              last,
        input logic [DEF_LANES*DEF_DATA_W-1:0]   lanes
    );
        logic [DEF_LINK_WIDTH-1:0] word;
        word                               = '0;
        word[LINK_VALID_BIT]               = valid;
        word[LINK_LAST_BIT]                = last;
        word[DEF_LANES*DEF_DATA_W-1:0]     = lanes;
        return word;
    endfunction

endpackage

// File: rtl/pe_link_lane_acc.sv
// Lane accumulator: collects up to LANES stream words into one group, zero-filling
// lanes a short packet never writes.
module pe_link_lane_acc
    import pe_link_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_last,
    input  logic                     clr,
    output logic [LANES*DATA_W-1:0]  lanes,
    output logic                     acc_full,
    output logic                     acc_last,
    output logic                     partial
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [CNT_W-1:0] count;
    logic             closes;

    assign closes  = wr_en && (wr_last || count == CNT_W'(LANES - 1));
    assign partial = (count != '0);

    // NOTE: every register here uses non-blocking assignment so the clear-then-write
    // ordering below resolves by statement order within one edge, without races.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc_full <= 1'b0;
            acc_last <= 1'b0;
            // NOTE: the lane storage is reset on purpose: unwritten lanes must read as
            // zero padding, so clearing it is functional, not cosmetic.
            lanes    <= '0;
        end else begin
            // A move empties the group; a word accepted on the same edge starts the next one.
            if (clr) begin
                lanes    <= '0;
                acc_full <= 1'b0;
            end
            if (wr_en) begin
                for (int i = 0; i < LANES; i++) begin
                    if (count == CNT_W'(i)) begin
                        lanes[lane_offset(i, DATA_W) +: DATA_W] <= wr_data;
                    end
                end
                count <= closes ? '0 : count + 1'b1;
            end
            if (closes) begin
                acc_full <= 1'b1;
                acc_last <= wr_last;
            end
        end
    end

endmodule

// File: rtl/pe_link_packer.sv
// Stream-to-link packer feeding a PE input; ap_start is the link accept strobe.
// Optional macro PE_LINK_PACKER_READY_LOOKAHEAD_EN lets s_ready look through a move.
module pe_link_packer
    import pe_link_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LANES      = DEF_LANES,
    parameter int LINK_WIDTH = DEF_LINK_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ap_start,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [LINK_WIDTH-1:0]  out_link,
    output logic                   busy
);

    generate
        if (LINK_WIDTH != LANES * DATA_W + 2) begin : g_bad_link_width
            $error("pe_link_packer: LINK_WIDTH must equal LANES*DATA_W+2");
        end
    endgenerate

    logic [LANES*DATA_W-1:0] acc_lanes;
    logic                    acc_full;
    logic                    acc_last;
    logic                    acc_partial;
    logic                    out_pending;
    logic                    move;
    logic                    accept;

    assign out_pending = out_link[LINK_WIDTH-1];
    assign move        = acc_full && (!out_pending || ap_start);

`ifdef PE_LINK_PACKER_READY_LOOKAHEAD_EN
    assign s_ready = !reset && (!acc_full || move);
`else
    assign s_ready = !reset && !acc_full;
`endif

    assign accept = s_valid && s_ready;

    pe_link_lane_acc #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_lane_acc (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_data  (s_data),
        .wr_last  (s_last),
        .clr      (move),
        .lanes    (acc_lanes),
        .acc_full (acc_full),
        .acc_last (acc_last),
        .partial  (acc_partial)
    );

    // A move overrides a transfer so back-to-back words keep valid high with no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_link <= '0;
        end else if (move) begin
            out_link <= {1'b1, acc_last, acc_lanes};
        end else if (out_pending && ap_start) begin
            out_link <= '0;
        end
    end

    assign busy = acc_full || acc_partial || out_pending;

endmodule

// File: tb/tb_pe_link_packer.sv
// Self-checking bench for pe_link_packer: per-cycle vector table plus hand-written
// backpressure, reset, streaming and random-traffic sequences.
module tb_pe_link_packer;
    import pe_link_pkg::*;

    localparam int DW = 32;
    localparam int LN = 4;
    localparam int LW = 130;
`ifdef PE_LINK_PACKER_READY_LOOKAHEAD_EN
    localparam bit LA = 1'b1;
`else
    localparam bit LA = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ap_start;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [LW-1:0] out_link;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_link_packer #(
        .DATA_W     (DW),
        .LANES      (LN),
        .LINK_WIDTH (LW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ap_start (ap_start),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .out_link (out_link),
        .busy     (busy)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          ap;
        logic          rdy;
        logic [LW-1:0] link;
        logic          bsy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] grp(input logic [DW-1:0] w0, w1, w2, w3, input logic last);
        return pack_link(1'b1, last, {w3, w2, w1, w0});
    endfunction

    // Presents one word and holds it until accepted; starts and ends on a falling edge.
    task automatic push(input logic [DW-1:0] d, input logic l);
        int budget;
        budget  = 50;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=ready_low required=ready_high");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0]      exp_q[$];
        logic [LN*DW-1:0]   m_lanes;
        int                 m_cnt;
        int                 sent, got, groups, budget;
        int                 idx, cyc, low, outs;

        reset    = 1'b1;
        ap_start = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_link", out_link, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_s_ready", s_ready, 1'b0);
        reset = 1'b0;

        // Full group then short packet, one row per clock.
        vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, '0, 1'b1};
        vecs[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, '0, 1'b1};
        vecs[2] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, '0, 1'b1};
        vecs[3] = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b1, '0, 1'b1};
        vecs[4] = '{1'b0, 32'h0,  1'b0, 1'b1, LA,
                    grp(32'h11, 32'h22, 32'h33, 32'h44, 1'b0), 1'b1};
        vecs[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, '0, 1'b0};
        vecs[6] = '{1'b1, 32'hAA, 1'b0, 1'b1, 1'b1, '0, 1'b1};
        vecs[7] = '{1'b1, 32'hBB, 1'b1, 1'b1, 1'b1, '0, 1'b1};
        vecs[8] = '{1'b0, 32'h0,  1'b0, 1'b1, LA,
                    grp(32'hAA, 32'hBB, 32'h0, 32'h0, 1'b1), 1'b1};
        vecs[9] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, '0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            s_valid  = vecs[i].v;
            s_data   = vecs[i].d;
            s_last   = vecs[i].l;
            ap_start = vecs[i].ap;
            #1;
            check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d_out_link", i), out_link, vecs[i].link);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
        end
        s_valid = 1'b0;

        // Backpressure: two groups pile up with ap_start low, then drain back to back.
        ap_start = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h101 + i, 1'b0);
        check("bp_s_ready", s_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        check("bp_hold0", out_link, grp(32'h101, 32'h102, 32'h103, 32'h104, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", out_link, grp(32'h101, 32'h102, 32'h103, 32'h104, 1'b0));
        end
        ap_start = 1'b1;
        @(negedge clk);
        check("bp_second", out_link, grp(32'h105, 32'h106, 32'h107, 32'h108, 1'b0));
        check("bp_second_busy", busy, 1'b1);
        @(negedge clk);
        check("bp_drained", out_link, '0);
        check("bp_drained_busy", busy, 1'b0);

        // Reset mid-packet discards the partial group.
        push(32'h1, 1'b0);
        push(32'h2, 1'b0);
        check("mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_link", out_link, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_s_ready", s_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_after_s_ready", s_ready, 1'b1);
        for (int i = 0; i < 4; i++) push(32'h5 + i, 1'b0);
        @(negedge clk);
        check("mid_clean_word", out_link, grp(32'h5, 32'h6, 32'h7, 32'h8, 1'b0));
        @(negedge clk);
        check("mid_clean_gone", out_link, '0);

        // Streaming: s_valid held high for 16 words with ap_start high.
        ap_start = 1'b1;
        idx = 0; cyc = 0; low = 0; outs = 0; budget = 100;
        while ((idx < 16 || outs < 4) && budget > 0) begin
            budget--;
            s_valid = (idx < 16);
            s_data  = 32'h5000 + idx;
            s_last  = 1'b0;
            #1;
            if (idx < 16) begin
                cyc++;
                if (s_ready) idx++;
                else low++;
            end
            if (out_link[LW-1]) begin
                check("stream_word", out_link,
                      grp(32'h5000 + 4*outs, 32'h5001 + 4*outs,
                          32'h5002 + 4*outs, 32'h5003 + 4*outs, 1'b0));
                outs++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("stream_words_out", outs, 4);
        // 16 accepts plus one ready bubble between each pair of groups in the base build.
        check("stream_accept_cycles", cyc, LA ? 16 : 19);
        check("stream_ready_low", low, LA ? 0 : 3);

        // Random traffic against a reference accumulator.
        m_lanes = '0; m_cnt = 0; sent = 0; got = 0; groups = 0; budget = 20000;
        while ((sent < 1000 || exp_q.size() != 0) && budget > 0) begin
            budget--;
            ap_start = ($urandom_range(0, 2) != 0) || (sent >= 1000);
            s_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            s_data   = 32'h1000_0000 + sent;
            s_last   = (sent == 999) || ($urandom_range(0, 6) == 0);
            #1;
            if (s_valid && s_ready) begin
                m_lanes[m_cnt*DW +: DW] = s_data;
                m_cnt++;
                sent++;
                if (m_cnt == LN || s_last) begin
                    exp_q.push_back(pack_link(1'b1, s_last, m_lanes));
                    m_lanes = '0;
                    m_cnt   = 0;
                    groups++;
                end
            end
            if (out_link[LW-1] && ap_start) begin
                if (exp_q.size() == 0) check("rnd_extra_word", out_link, '0);
                else check("rnd_word", out_link, exp_q.pop_front());
                got++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("rnd_words_sent", sent, 1000);
        check("rnd_queue_empty", exp_q.size(), 0);
        check("rnd_link_count", got, groups);
        ap_start = 1'b1;
        repeat (3) @(negedge clk);
        check("rnd_final_out_link", out_link, '0);
        check("rnd_final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_link_packer.md
Name: pe_link_packer

Overview:
- Stream-to-link packer that sits directly upstream of an overlay PE tile.
- Accepts a 32-bit valid/ready word stream from a leaf operator and packs up to LANES words into one LINK_WIDTH link word.
- Drives the link word into a PE input (e.g. in_from_west). That PE samples its input only in cycles where ap_start=1, so ap_start acts as the link's "accept" strobe.

Parameters:
- DATA_W, 32, width of one stream word.
- LANES, 4, words per link word.
- LINK_WIDTH, 130, link width; must equal LANES*DATA_W+2 (checked by elaboration-time assertion).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  downstream PE sample enable; a pending link word transfers on any rising edge with ap_start=1.
- s_data  in  DATA_W  input word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final word of a packet.
- s_ready  out  1  packer can accept s_data this cycle.
- out_link  out  LINK_WIDTH  registered link word.
- busy  out  1  accumulator non-empty or output word pending.

Behaviour:
- Link format:
  - bit LINK_WIDTH-1 = valid.
  - bit LINK_WIDTH-2 = last.
  - lane i occupies bits [i*DATA_W +: DATA_W]; lane 0 holds the first word of the group.
- Reset: out_link=0, s_ready=0 during reset (1 in the first cycle after), lane count=0, acc_full=0, busy=0. Reset mid-packet discards all accumulated and pending data.
- Input accept: a word is accepted on an edge where s_valid && s_ready. It is written to lane[count], and count increments.
- acc_full is set on the edge that accepts the word with count==LANES-1, or any word with s_last=1. On that edge:
  - count returns to 0.
  - the last flag is latched.
  - lanes not written in this group are zero-filled.
- s_ready = !acc_full (base build).
- Output register: out_pending = out_link valid bit.
- move = acc_full && (!out_pending || ap_start). On a move edge:
  - out_link <= {1, last, lanes}.
  - acc_full clears and the accumulator lanes clear to 0.
- Transfer: on an edge with out_pending && ap_start && !move, out_link <= 0. The valid bit therefore stays high for exactly one sampled cycle.
- Hold: with ap_start=0, out_link stays stable. A second group may complete in the accumulator; s_ready then stays 0 until a move.
- Latency:
  - 4th word accepted at edge E.
  - move at E+1 (out_link valid visible after E+1).
  - PE captures at E+2 if ap_start=1.
- Throughput (base): LANES words per LANES+1 cycles, because s_ready is low for one cycle after each group.
- Simultaneous transfer and move on the same edge: the new word replaces the old one; valid stays 1; no gap.
- s_last with count==LANES-1: a normal full group with last=1.
- A packet's lane count is not encoded. Receivers treat trailing zero lanes as padding, by protocol.
- busy = acc_full || count!=0 || out_pending.

Optional Feature:
- Macro: PE_LINK_PACKER_READY_LOOKAHEAD_EN.
- Defined: s_ready = !acc_full || move (combinational through ap_start). On a move edge, an accepted word goes to lane 0 of the fresh group. Sustained throughput becomes one word per cycle.
- Undefined: registered-only ready as above; no combinational path from ap_start to s_ready.

Decomposition:
- Shared package pe_link_pkg holds:
  - link field constants: LINK_VALID_BIT, LINK_LAST_BIT, lane offset function.
  - default DATA_W, LANES, LINK_WIDTH.
  - a link-word pack helper function.
- One natural sub-module: pe_link_lane_acc, containing the lane registers, count, acc_full and last. The top keeps the output register, move/transfer logic and ready.

Test Plan:
- Full group, ap_start=1: words 0x11,0x22,0x33,0x44 (last=0) -> out_link valid for exactly one cycle, two edges after the 4th accept; lanes 0..3 = 0x11..0x44, last bit=0; then out_link=0.
- Short packet: 0xAA, then 0xBB with s_last -> one word with lane0=0xAA, lane1=0xBB, lanes2-3=0, last bit=1.
- Backpressure: ap_start=0, send 8 words -> first word held stable on out_link, s_ready=0 after the 8th accept, busy=1. Raise ap_start -> two valid link words on consecutive cycles, then out_link=0, busy=0.
- Reset mid-packet: accept 0x1,0x2, assert reset one cycle -> out_link=0, busy=0. Then 0x5..0x8 -> one clean word with lane0=0x5.
- Streaming: 16 words, s_valid constant, ap_start=1 -> 4 link words in order. Base: s_ready low one cycle per group, 20 cycles total. With macro: s_ready constant 1, 16 accept cycles.
- Random: random s_valid/ap_start for 1000 words -> reassembled output matches input order; no word is lost or duplicated.
